// File: rtl/mem_io_ctrl_if.sv
// CPU external-bus and display-stream signal bundle for mem_io_ctrl.
// master: CPU / display sink side; slave: the memory-and-I/O controller.
interface mem_io_ctrl_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
);
    logic              write_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              disp_ready;
    logic              disp_frame_start;

    modport master (
        output write_en, addr, data_in, disp_ready,
        input  data_out, disp_data, disp_valid, disp_frame_start
    );

    modport slave (
        input  write_en, addr, data_in, disp_ready,
        output data_out, disp_data, disp_valid, disp_frame_start
    );
endinterface

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: 1K x 16 RAM, 16-word MMIO window and a RAM-to-display streamer.
// The CPU port never stalls; every read returns one clock after its address.
// Optional macro MEM_IO_TIMER_EN builds TIMER/TCMP/STATUS and irq; without it
// those offsets read 0, ignore writes, and irq is tied low.
module mem_io_ctrl #(
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [ADDR_W-1:0] IO_BASE   = 10'h3F0,
    parameter logic [ADDR_W-1:0] DISP_BASE = 10'h200,
    parameter int unsigned       DISP_LEN  = 64
) (
    input  logic               clk,
    input  logic               reset,
    mem_io_ctrl_if.slave       bus,
    input  logic [9:0]         sw_in,
    output logic [9:0]         led_out,
    output logic               irq
);
    localparam int unsigned IDX_W = 8;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] ram_a_q, ram_b_q;

    logic [ADDR_W-1:0] io_off;
    logic [3:0]        io_sel;
    logic              is_io, io_we;
    logic [ADDR_W-1:0] disp_addr;

    logic [9:0]        sw_meta_q, sw_sync_q;
    logic [9:0]        led_q, led_d;
    logic              dctrl_q, dctrl_d;
    logic              sel_ram_q, sel_ram_d;
    logic [DATA_W-1:0] io_rd_q, io_rd_d;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              fs_q, fs_d;
    logic              loaded_q, loaded_d;

`ifdef MEM_IO_TIMER_EN
    logic [15:0]       timer_q, timer_d;
    logic [15:0]       tcmp_q, tcmp_d;
    logic              match_q, match_d;
    logic              ie_q, ie_d;
`endif

    // Address decode for the MMIO window and the streamer's RAM address.
    always_comb begin
        io_off    = bus.addr - IO_BASE;
        is_io     = (bus.addr >= IO_BASE) && (io_off < ADDR_W'(16));
        io_sel    = io_off[3:0];
        io_we     = bus.write_en && is_io;
        disp_addr = DISP_BASE + ADDR_W'(idx_q);
    end

    // RAM with CPU port A (read-before-write) and display port B.
    always_ff @(posedge clk) begin
        if (bus.write_en && !is_io && !reset)
            mem[bus.addr] <= bus.data_in;
        ram_a_q <= mem[bus.addr];
        if (state_q == FETCH)
            ram_b_q <= mem[disp_addr];
    end

    // MMIO register next-state and read mux (reads see pre-write values).
    always_comb begin
        led_d     = led_q;
        dctrl_d   = dctrl_q;
        sel_ram_d = !is_io;
        io_rd_d   = '0;
`ifdef MEM_IO_TIMER_EN
        timer_d = timer_q + 16'd1;
        tcmp_d  = tcmp_q;
        ie_d    = ie_q;
        match_d = match_q;
`endif
        case (io_sel)
            4'd0:    io_rd_d = DATA_W'(sw_sync_q);
            4'd1:    io_rd_d = DATA_W'(led_q);
`ifdef MEM_IO_TIMER_EN
            4'd2:    io_rd_d = DATA_W'(timer_q);
            4'd3:    io_rd_d = DATA_W'(tcmp_q);
            4'd4:    io_rd_d = DATA_W'({ie_q, match_q});
`endif
            4'd5:    io_rd_d = DATA_W'(dctrl_q);
            default: io_rd_d = '0;
        endcase
        if (io_we) begin
            case (io_sel)
                4'd1:    led_d   = bus.data_in[9:0];
`ifdef MEM_IO_TIMER_EN
                4'd2:    timer_d = '0;
                4'd3:    tcmp_d  = bus.data_in[15:0];
                4'd4: begin
                    ie_d = bus.data_in[1];
                    if (bus.data_in[0])
                        match_d = 1'b0;
                end
`endif
                4'd5:    dctrl_d = bus.data_in[0];
                default: ;
            endcase
        end
`ifdef MEM_IO_TIMER_EN
        // Evaluated after the clear so a simultaneous set wins.
        if (timer_q == tcmp_q && tcmp_q != '0)
            match_d = 1'b1;
`endif
    end

    // Display streamer next-state: one word per FETCH/HOLD pair.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        fs_d     = fs_q;
        loaded_d = loaded_q;
        case (state_q)
            IDLE: begin
                if (dctrl_q)
                    state_d = FETCH;
            end
            FETCH: begin
                state_d  = HOLD;
                valid_d  = 1'b1;
                fs_d     = (idx_q == '0);
                loaded_d = 1'b1;
            end
            HOLD: begin
                if (bus.disp_ready) begin
                    valid_d = 1'b0;
                    fs_d    = 1'b0;
                    if (dctrl_q) begin
                        state_d = FETCH;
                        idx_d   = (idx_q == IDX_W'(DISP_LEN - 1)) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All controller state: synchronizer, MMIO registers and streamer FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            led_q     <= '0;
            dctrl_q   <= 1'b0;
            sel_ram_q <= 1'b0;
            io_rd_q   <= '0;
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            fs_q      <= 1'b0;
            loaded_q  <= 1'b0;
`ifdef MEM_IO_TIMER_EN
            timer_q   <= '0;
            tcmp_q    <= '0;
            match_q   <= 1'b0;
            ie_q      <= 1'b0;
`endif
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
            led_q     <= led_d;
            dctrl_q   <= dctrl_d;
            sel_ram_q <= sel_ram_d;
            io_rd_q   <= io_rd_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            fs_q      <= fs_d;
            loaded_q  <= loaded_d;
`ifdef MEM_IO_TIMER_EN
            timer_q   <= timer_d;
            tcmp_q    <= tcmp_d;
            match_q   <= match_d;
            ie_q      <= ie_d;
`endif
        end
    end

    assign bus.data_out         = sel_ram_q ? ram_a_q : io_rd_q;
    assign bus.disp_data        = loaded_q ? ram_b_q : '0;
    assign bus.disp_valid       = valid_q;
    assign bus.disp_frame_start = fs_q;
    assign led_out              = led_q;
`ifdef MEM_IO_TIMER_EN
    assign irq = match_q & ie_q;
`else
    assign irq = 1'b0;
`endif
endmodule

// File: doc/mem_io_ctrl.md
Name: mem_io_ctrl

Overview:
- Memory and I/O subsystem directly downstream of the CPU's external bus (the write_en/addr/data_in/data_out port used when the CPU is built with its internal RAM overridden).
- Holds the 1K x 16 program/data RAM, decodes a 16-word memory-mapped I/O window, and streams a RAM region to a display sink through a second read port with a valid/ready handshake.
- The CPU port never stalls. Every CPU read returns data exactly one clock after the address is presented.

Parameters:
ADDR_W, 10, CPU word-address width
DATA_W, 16, data word width
IO_BASE, 10'h3F0, base of the 16-word MMIO window (IO_BASE..IO_BASE+15)
DISP_BASE, 10'h200, first RAM word streamed to the display
DISP_LEN, 64, words per display frame (1..256)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
write_en  input  1  CPU write strobe
addr  input  ADDR_W  CPU word address
data_in  input  DATA_W  CPU write data
data_out  output  DATA_W  CPU read data, registered
sw_in  input  10  raw board switches, asynchronous
led_out  output  10  LED register
disp_data  output  DATA_W  streamed word
disp_valid  output  1  disp_data valid
disp_ready  input  1  sink accepts the word
disp_frame_start  output  1  high together with the first word of each frame
irq  output  1  timer-match interrupt level

Behaviour:
Reset values:
- data_out=0, led_out=0, disp_data=0, disp_valid=0, disp_frame_start=0, irq=0.
- All MMIO registers 0 and stream index 0.
- RAM contents are not cleared.

CPU port:
- Address decode: addr in [IO_BASE, IO_BASE+15] is MMIO; every other address is RAM.
- Write: write_en=1 writes data_in at posedge.
- A write to the MMIO window never modifies RAM.
- Read: data_out at posedge N+1 reflects addr at posedge N, for both RAM and MMIO.
- A write cycle also returns the old contents on data_out (read-before-write).

MMIO map (offset from IO_BASE):
- 0 SW (read-only): sw_in passed through a 2-flop synchronizer, zero-extended. Writes are ignored.
- 1 LED (read/write): bits[9:0] drive led_out. Reads return zero-extended bits.
- 2 TIMER (read/write): free-running 16-bit up-counter, wraps 0xFFFF->0. Any write loads 0.
- 3 TCMP (read/write): compare value.
- 4 STATUS:
  - bit0 = sticky timer-match flag, set when TIMER==TCMP and TCMP!=0.
  - Writing 1 to bit0 clears it.
  - If a set and a clear occur in the same cycle, set wins.
  - irq = bit0 AND STATUS.bit1; bit1 is the irq enable (read/write).
- 5 DCTRL: bit0 = stream enable (read/write).
- 6..15: reserved; reads return 0, writes are ignored.

Display streamer:
- FSM states: IDLE, FETCH, HOLD.
- IDLE: leave when DCTRL.bit0=1; go to FETCH.
- FETCH: port-B read of DISP_BASE+idx. Next cycle go to HOLD with disp_data loaded and disp_valid=1.
  - disp_frame_start=1 when idx==0.
- HOLD:
  - disp_data and disp_valid are held stable until disp_ready=1.
  - On accept: idx increments; DISP_LEN-1 wraps to 0.
  - After accept, go to FETCH if enable is still 1; otherwise go to IDLE and set idx=0.
- Clearing the enable mid-beat never drops a valid word; the current beat completes first.
- Maximum throughput is one word per 2 cycles.
- Port-B read of an address the CPU writes in the same cycle returns the old data.
- Reset in any state returns to IDLE, idx=0, disp_valid=0 in the following cycle.

Optional Feature:
- Macro: MEM_IO_TIMER_EN.
- Defined: TIMER, TCMP, STATUS and irq are implemented as described above.
- Undefined:
  - No counter logic is built.
  - Offsets 2..4 read 0 and ignore writes.
  - irq is tied to 0.

Test Plan:
- CPU RAM access: write 0xBEEF to 0x005, then read 0x005 -> data_out=0xBEEF one cycle after the read address. Write to 0x3F1 -> RAM[0x3F1] unchanged.
- MMIO I/O: sw_in=10'h2A5 held 3 cycles, read 0x3F0 -> 0x02A5. Write 0xFFFF to 0x3F1 -> led_out=10'h3FF; read back -> 0x03FF.
- Timer (MEM_IO_TIMER_EN defined):
  - Write TIMER=0, TCMP=5, STATUS=0x0002 -> irq rises once TIMER reaches 5.
  - Write STATUS=0x0001 -> irq=0.
  - Same test without the macro -> reads of 0x3F2 are 0 and irq stays 0.
- Stream with backpressure:
  - Setup: DISP_LEN=4, RAM[0x200..0x203]=1,2,3,4, DCTRL=1.
  - Hold disp_ready=0 for 5 cycles -> disp_data=1 stays stable with disp_valid=1.
  - Then hold disp_ready=1 -> words 1,2,3,4,1 are delivered, with disp_frame_start on both 1s.
- Disable mid-beat: clear DCTRL while in HOLD -> the pending word is still delivered on ready, then disp_valid=0 and the next enable restarts at word 1.
- Reset mid-stream: assert reset in HOLD -> next cycle disp_valid=0, led_out=0, data_out=0, and RAM contents are preserved.
